riscv_mc_controller: RTL and testbench

- Multicycle control FSM for the RV32I datapath; the command-side counterpart of the ALU.
- Decodes opcode/funct fields and drives ALU operand selects and the 3-bit ALU operation.
- Consumes the ALU zero/sign flags to resolve branches.
- Sequences fetch/decode/execute/memory/writeback with a ready handshake to unified memory.

---
 rtl/riscv_ctrl_pkg.sv | 51 +++++
 rtl/riscv_alu_decoder.sv | 37 +++
 rtl/riscv_mc_controller.sv | 161 ++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller and the ALU it drives.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Maps ALU operation class plus funct fields to the 3-bit ALU control code.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_e     aluop,
  input  logic       is_rtype,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);

  always_comb begin
    alu_control   = ALU_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SHL;
          3'b100: alu_control = ALU_XOR;
          // Arithmetic right shift has no ALU support, so it traps.
          3'b101: begin
            if (funct7b5) illegal_funct = 1'b1;
            else          alu_control   = ALU_SHR;
          end
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: illegal_funct = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM. Define CTRL_BRANCH_EXT_EN to add bne/blt/bge;
// without it only beq is accepted.
module riscv_mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit RESET_STATE_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_e state_q, state_d;
  aluop_e aluop;
  logic   illegal_funct, br_ok, br_taken;
  logic   pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  riscv_alu_decoder u_alu_dec (
    .aluop        (aluop),
    .is_rtype     (op == OP_RTYPE),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .alu_control  (alu_control),
    .illegal_funct(illegal_funct)
  );

  assign imm_src = imm_sel(op);

  // Signed overflow is deliberately ignored: blt/bge trust the raw sign bit.
  always_comb begin
    br_ok    = 1'b0;
    br_taken = 1'b0;
    case (funct3)
      3'b000: begin br_ok = 1'b1; br_taken = zero;  end
`ifdef CTRL_BRANCH_EXT_EN
      3'b001: begin br_ok = 1'b1; br_taken = ~zero; end
      3'b100: begin br_ok = 1'b1; br_taken = sign;  end
      3'b101: begin br_ok = 1'b1; br_taken = ~sign; end
`endif
      default: begin br_ok = 1'b0; br_taken = 1'b0; end
    endcase
  end

`ifndef CTRL_BRANCH_EXT_EN
  logic unused_sign;
  assign unused_sign = sign;
`endif

  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALU;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_FOUR;
    aluop         = ALUOP_ADD;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      // Precompute the branch/jump target into ALUOut while decoding.
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_RDATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = (state_q == S_EXECR) ? SRC_B_RS2 : SRC_B_IMM;
        aluop     = ALUOP_FUNCT;
        state_d   = illegal_funct ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        aluop        = ALUOP_SUB;
        result_src   = RES_ALUOUT;
        pc_write_raw = br_ok & br_taken;
        state_d      = br_ok ? S_FETCH : S_TRAP;
      end
      // Jump to the target from DECODE, then link oldPC+4 through ALUWB.
      S_JAL: begin
        alu_src_a    = SRC_A_OLDPC;
        alu_src_b    = SRC_B_FOUR;
        result_src   = RES_ALUOUT;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = RESET_STATE_TRAP ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Gating with rst_n kills a pending store in the same cycle reset arrives.
  assign pc_write  = pc_write_raw  & rst_n;
  assign ir_write  = ir_write_raw  & rst_n;
  assign mem_write = mem_write_raw & rst_n;
  assign reg_write = reg_write_raw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed plus random instruction bench for riscv_mc_controller with a
// per-instruction cycle-list reference model.
module tb_riscv_mc_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam int D = -1;

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero, sign, mem_ready;
  logic pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;
  logic s_pc_write, s_ir_write, s_adr_src, s_mem_write, s_reg_write, s_illegal;
  logic [1:0] s_result_src, s_alu_src_a, s_alu_src_b;
  logic [2:0] s_imm_src, s_alu_control;

  always #5 clk = ~clk;

  riscv_mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal)
  );

  riscv_mc_controller #(.RESET_STATE_TRAP(1'b1)) dut_sticky (
    .clk(clk), .rst_n(rst2_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .ir_write(s_ir_write), .adr_src(s_adr_src),
    .mem_write(s_mem_write), .reg_write(s_reg_write), .result_src(s_result_src),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .imm_src(s_imm_src),
    .alu_control(s_alu_control), .illegal(s_illegal)
  );

  typedef struct packed {
    logic pcw, irw, mw, rw, ill, adr;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
  } ctl_t;

  typedef struct {
    logic mr;
    ctl_t e;
    ctl_t m;
  } phase_t;

  phase_t q[$];
  int n_assert = 0, n_fail = 0;
  int exp_imm;
  logic [6:0] n_op;
  logic [2:0] n_f3;
  logic n_f7, n_z, n_s;

  function automatic ctl_t obs();
    return '{pcw:pc_write, irw:ir_write, mw:mem_write, rw:reg_write, ill:illegal,
             adr:adr_src, rs:result_src, sa:alu_src_a, sb:alu_src_b,
             alu:alu_control, imm:imm_src};
  endfunction

  function automatic ctl_t obs2();
    return '{pcw:s_pc_write, irw:s_ir_write, mw:s_mem_write, rw:s_reg_write,
             ill:s_illegal, adr:s_adr_src, rs:s_result_src, sa:s_alu_src_a,
             sb:s_alu_src_b, alu:s_alu_control, imm:s_imm_src};
  endfunction

  task automatic check(input string tag, input ctl_t o, input ctl_t e, input ctl_t m);
    n_assert++;
    assert ((o & m) === (e & m)) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h care=%h", tag, o, e, m);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One expected cycle; D marks a field the behaviour leaves unconstrained.
  function automatic void add(input logic mr, input int pcw, irw, mw, rw, ill,
                              adr, rs, sa, sb, alu);
    phase_t p;
    p.mr = mr;
    p.e.pcw = pcw[0]; p.e.irw = irw[0]; p.e.mw = mw[0]; p.e.rw = rw[0];
    p.e.ill = ill[0];
    p.m.pcw = 1'b1; p.m.irw = 1'b1; p.m.mw = 1'b1; p.m.rw = 1'b1; p.m.ill = 1'b1;
    p.e.adr = adr[0];      p.m.adr = (adr >= 0);
    p.e.rs  = rs[1:0];     p.m.rs  = {2{rs >= 0}};
    p.e.sa  = sa[1:0];     p.m.sa  = {2{sa >= 0}};
    p.e.sb  = sb[1:0];     p.m.sb  = {2{sb >= 0}};
    p.e.alu = alu[2:0];    p.m.alu = {3{alu >= 0}};
    p.e.imm = exp_imm[2:0]; p.m.imm = {3{exp_imm >= 0}};
    q.push_back(p);
  endfunction

  function automatic void alu_model(input logic [2:0] f3, input logic is_r,
                                    input logic f7, output int alu, output bit legal);
    legal = 1'b1;
    alu = 0;
    case (f3)
      3'd0: alu = (is_r && f7) ? 2 : 0;
      3'd1: alu = 1;
      3'd4: alu = 4;
      3'd5: if (f7) legal = 1'b0; else alu = 5;
      3'd6: alu = 6;
      3'd7: alu = 7;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic void branch_model(input logic [2:0] f3, input logic z, input logic s,
                                       output bit ok, output bit taken);
    ok = 1'b0;
    taken = 1'b0;
    if (f3 == 3'd0) begin ok = 1'b1; taken = z; end
`ifdef CTRL_BRANCH_EXT_EN
    else if (f3 == 3'd1) begin ok = 1'b1; taken = !z; end
    else if (f3 == 3'd4) begin ok = 1'b1; taken = s;  end
    else if (f3 == 3'd5) begin ok = 1'b1; taken = !s; end
`endif
  endfunction

  function automatic void trap_cycle();
    add(rb(), 0, 0, 0, 0, 1, D, D, D, D, D);
  endfunction

  function automatic void wb_cycle(input int rs);
    add(rb(), 0, 0, 0, 1, 0, D, rs, D, D, D);
  endfunction

  // Expected control trace for one whole instruction, fetch through retire.
  function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input int fw, input int mwt, input logic z, input logic s);
    int alu;
    bit legal, ok, taken;
    logic is_r;
    is_r = (o == RT);
    case (o)
      LW, IT:  exp_imm = 0;
      SW:      exp_imm = 1;
      BR:      exp_imm = 2;
      JL:      exp_imm = 3;
      default: exp_imm = D;
    endcase
    for (int i = 0; i < fw; i++) add(1'b0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    add(1'b1, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0);
    add(rb(), 0, 0, 0, 0, 0, D, D, 1, 1, 0);
    case (o)
      LW: begin
        add(rb(), 0, 0, 0, 0, 0, D, D, 2, 1, 0);
        for (int i = 0; i < mwt; i++) add(1'b0, 0, 0, 0, 0, 0, 1, D, D, D, D);
        add(1'b1, 0, 0, 0, 0, 0, 1, D, D, D, D);
        wb_cycle(1);
      end
      SW: begin
        add(rb(), 0, 0, 0, 0, 0, D, D, 2, 1, 0);
        for (int i = 0; i < mwt; i++) add(1'b0, 0, 0, 1, 0, 0, 1, D, D, D, D);
        add(1'b1, 0, 0, 1, 0, 0, 1, D, D, D, D);
      end
      RT, IT: begin
        alu_model(f3, is_r, f7, alu, legal);
        add(rb(), 0, 0, 0, 0, 0, D, D, 2, is_r ? 0 : 1, legal ? alu : D);
        if (legal) wb_cycle(0);
        else trap_cycle();
      end
      BR: begin
        branch_model(f3, z, s, ok, taken);
        add(rb(), (ok && taken) ? 1 : 0, 0, 0, 0, 0, D, 0, 2, 0, 2);
        if (!ok) trap_cycle();
      end
      JL: begin
        add(rb(), 1, 0, 0, 0, 0, D, 0, 1, 2, 0);
        wb_cycle(0);
      end
      default: trap_cycle();
    endcase
  endfunction

  task automatic run(input string tag, input int limit);
    int k;
    phase_t p;
    k = 0;
    while (q.size() > 0) begin
      p = q.pop_front();
      if (k < limit) begin
        @(negedge clk);
        if (k == 0) begin
          op = n_op; funct3 = n_f3; funct7b5 = n_f7; zero = n_z; sign = n_s;
        end
        mem_ready = p.mr;
        #1;
        check($sformatf("%s[%0d]", tag, k), obs(), p.e, p.m);
      end
      k++;
    end
  endtask

  task automatic instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input int fw, input int mwt, input logic z,
                       input logic s, input int limit = 1000);
    n_op = o; n_f3 = f3; n_f7 = f7; n_z = z; n_s = s;
    build(o, f3, f7, fw, mwt, z, s);
    run(tag, limit);
  endtask

  task automatic check_reset(input string tag);
    ctl_t e, m;
    e = '{pcw:0, irw:0, mw:0, rw:0, ill:0, adr:0, rs:2'b10, sa:2'b00, sb:2'b10,
          alu:3'b000, imm:3'b000};
    m = '1;
    m.imm = 3'b000;
    check(tag, obs(), e, m);
  endtask

  initial begin
    logic [6:0] ops [8];
    ctl_t se, sm;
    ops = '{LW, SW, RT, IT, BR, JL, LUI, 7'h00};
    rst_n = 1'b0; rst2_n = 1'b0; mem_ready = 1'b1;
    op = SW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; sign = 1'b0;
    #12;
    @(negedge clk); #1; check_reset("reset0");
    @(negedge clk); #1; check_reset("reset1");
    @(negedge clk); mem_ready = 1'b0; rst_n = 1'b1;

    instr("fetch_wait_lw", LW, 3'd2, 1'b0, 3, 1, 1'b0, 1'b0);
    instr("sub",  RT, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
    instr("addi", IT, 3'd0, 1'b1, 1, 0, 1'b0, 1'b0);
    instr("sw_wait", SW, 3'd2, 1'b0, 0, 2, 1'b0, 1'b0);

    // Store interrupted by reset after two held write cycles.
    instr("sw_rst", SW, 3'd2, 1'b0, 0, 5, 1'b0, 1'b0, 5);
    @(negedge clk); mem_ready = 1'b1; rst_n = 1'b0; #1;
    check_reset("sw_rst_drop");
    @(negedge clk); mem_ready = 1'b0; rst_n = 1'b1;
    instr("after_rst", RT, 3'd7, 1'b0, 0, 0, 1'b0, 1'b0);

    instr("beq_t",  BR, 3'd0, 1'b0, 0, 0, 1'b1, 1'b0);
    instr("beq_nt", BR, 3'd0, 1'b0, 0, 0, 1'b0, 1'b1);
    instr("blt_s",  BR, 3'd4, 1'b0, 0, 0, 1'b0, 1'b1);
    instr("bge_s",  BR, 3'd5, 1'b0, 0, 0, 1'b0, 1'b1);
    instr("bne",    BR, 3'd1, 1'b0, 0, 0, 1'b0, 1'b0);
    instr("jal",    JL, 3'd3, 1'b1, 1, 0, 1'b0, 1'b0);
    instr("lui",    LUI, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    instr("slt",    RT, 3'd2, 1'b0, 0, 0, 1'b0, 1'b0);
    instr("sra",    RT, 3'd5, 1'b1, 0, 0, 1'b0, 1'b0);
    instr("srl",    RT, 3'd5, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      logic [6:0] o;
      o = ops[$urandom_range(0, 7)];
      if (o == 7'h00) o = 7'($urandom);
      instr($sformatf("rnd%0d", i), o, 3'($urandom), rb(), $urandom_range(0, 2),
            $urandom_range(0, 2), rb(), rb());
    end

    // Sticky-trap instance: illegal opcode must hold TRAP indefinitely.
    op = LUI; funct3 = 3'd0; funct7b5 = 1'b0;
    @(negedge clk); mem_ready = 1'b1; rst2_n = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    se = '0; se.ill = 1'b1;
    sm = '0; sm.pcw = 1'b1; sm.irw = 1'b1; sm.mw = 1'b1; sm.rw = 1'b1; sm.ill = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); mem_ready = rb(); #1;
      check($sformatf("sticky_trap[%0d]", i), obs2(), se, sm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
